// File: rtl/fifo_rw_pkg.sv
// ---------------------------------------------------------------------------
// fifo_rw_pkg
// Shared types and constants for the FIFO burst reader and its output buffer.
//   state_e   : burst reader FSM state (IDLE, RUN, DONE)
//   OCC_W     : width of the output-buffer occupancy count
//   OCC_FULL  : occupancy at which the 2-entry output buffer is full
//   is_busy() : true for the states in which the reader owns the FIFO
// ---------------------------------------------------------------------------
package fifo_rw_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int              OCC_W    = 2;
    localparam logic [OCC_W-1:0] OCC_FULL = 2'd2;

    function automatic logic is_busy(input state_e s);
        return (s == RUN) || (s == DONE);
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// ---------------------------------------------------------------------------
// skid_buf2
// Two-entry in-order output buffer carrying {last, data}. The head entry is
// the registered downstream output; the second entry absorbs one word while
// the downstream is stalled.
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   push       : write push_entry this cycle (never asserted when occ==2)
//   push_entry : {last, data} word being written
//   ready      : downstream accept
//   valid      : head entry valid (registered)
//   head       : head entry {last, data} (registered)
//   occ        : number of occupied entries, 0..2
// Handshake: a word leaves the head on a rising edge where valid & ready;
// head stays unchanged while valid=1 and ready=0.
// ---------------------------------------------------------------------------
module skid_buf2
    import fifo_rw_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [DATA_W:0]  push_entry,
    input  logic             ready,
    output logic             valid,
    output logic [DATA_W:0]  head,
    output logic [OCC_W-1:0] occ
);

    logic            head_v;
    logic            skid_v;
    logic [DATA_W:0] head_q;
    logic [DATA_W:0] skid_q;
    logic            xfer;

    assign xfer  = head_v & ready;
    assign valid = head_v;
    assign head  = head_q;
    assign occ   = {1'b0, head_v} + {1'b0, skid_v};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_v <= 1'b0;
            skid_v <= 1'b0;
            head_q <= '0;
            skid_q <= '0;
        end else begin
            case ({skid_v, head_v})
                2'b00: begin
                    if (push) begin
                        head_q <= push_entry;
                        head_v <= 1'b1;
                    end
                end
                2'b01: begin
                    // Simultaneous push and transfer: the new word moves
                    // straight into the head, occupancy stays at one.
                    if (push && xfer) begin
                        head_q <= push_entry;
                    end else if (push) begin
                        skid_q <= push_entry;
                        skid_v <= 1'b1;
                    end else if (xfer) begin
                        head_v <= 1'b0;
                    end
                end
                2'b11: begin
                    if (xfer) begin
                        head_q <= skid_q;
                        if (push) begin
                            skid_q <= push_entry;
                        end else begin
                            skid_v <= 1'b0;
                        end
                    end
                end
                default: begin
                    // Second entry without a head cannot occur; recover empty.
                    head_v <= 1'b0;
                    skid_v <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// fifo_burst_reader
// Drains a requested number of words from a show-ahead FIFO and streams them
// downstream with valid/ready, marking the last word of the burst.
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   start       : one-cycle burst request, honoured only in IDLE
//   burst_len   : words to drain, sampled with start (0 = empty burst)
//   busy        : high in RUN and DONE
//   done        : one-cycle pulse when the burst completes
//   fifo_empty  : upstream FIFO empty flag
//   fifo_dout   : show-ahead head word, valid while fifo_empty=0
//   fifo_rd_en  : pop strobe; next head appears the following cycle
//   m_valid     : downstream word valid (registered)
//   m_data      : downstream word (registered)
//   m_last      : final word of the burst, qualified by m_valid (registered)
//   m_ready     : downstream accept
//   fsm_state   : current FSM state, for observation
// Handshake: a downstream transfer happens on a rising edge where
// m_valid & m_ready; m_data/m_last hold while m_valid=1 and m_ready=0, and
// m_valid never depends combinationally on m_ready.
// ---------------------------------------------------------------------------
module fifo_burst_reader
    import fifo_rw_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    output logic              busy,
    output logic              done,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output state_e            fsm_state
);

    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    state_e           state;
    logic [LEN_W-1:0] pop_cnt;
    logic [LEN_W-1:0] out_cnt;
    logic [OCC_W-1:0] occ;
    logic             xfer;
    logic [DATA_W:0]  push_entry;
    logic [DATA_W:0]  head;

    assign fsm_state = state;
    assign xfer      = m_valid & m_ready;

    // Pop decision uses only registered state and the FIFO flag; it never
    // looks at m_ready, so a full buffer simply blocks the pop for a cycle.
    assign fifo_rd_en = (state == RUN) & ~fifo_empty & (pop_cnt != '0) & (occ < OCC_FULL);

    // Words leave in pop order, so the word popped while pop_cnt==1 is the
    // one that will be transferred while out_cnt==1: tag it as last on entry.
    assign push_entry = {(pop_cnt == CNT_ONE), fifo_dout};

    skid_buf2 #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_rd_en),
        .push_entry (push_entry),
        .ready      (m_ready),
        .valid      (m_valid),
        .head       (head),
        .occ        (occ)
    );

    assign m_last = head[DATA_W];
    assign m_data = head[DATA_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pop_cnt <= '0;
            out_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (burst_len != '0) begin
                            pop_cnt <= burst_len;
                            out_cnt <= burst_len;
                            state   <= RUN;
                        end else begin
                            // Empty burst: nothing to pop, report completion.
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // fifo_rd_en already implies pop_cnt != 0.
                    if (fifo_rd_en) begin
                        pop_cnt <= pop_cnt - CNT_ONE;
                    end
                    if (xfer && (out_cnt != '0)) begin
                        out_cnt <= out_cnt - CNT_ONE;
                        if (out_cnt == CNT_ONE) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_burst_reader
// Self-checking bench for fifo_burst_reader. A show-ahead FIFO is modelled
// with an array and pointers; expected downstream words are the first
// burst_len words loaded into the FIFO, last flag on the final one.
// ---------------------------------------------------------------------------
module tb_fifo_burst_reader;
    import fifo_rw_pkg::*;

    localparam int DATA_W = 4;
    localparam int LEN_W  = 8;
    localparam int DEPTH  = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [LEN_W-1:0]  burst_len;
    logic              busy;
    logic              done;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_rd_en;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;
    state_e            fsm_state;

    int errors = 0;
    int checks = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    fifo_burst_reader #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .burst_len  (burst_len),
        .busy       (busy),
        .done       (done),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .fsm_state  (fsm_state)
    );

    // ---------------- show-ahead FIFO model ----------------
    logic [DATA_W-1:0] mem [DEPTH];
    int   rd_ptr = 0;
    int   wr_ptr = 0;
    logic hold_empty;
    logic [DATA_W-1:0] src_q[$];

    assign fifo_empty = (rd_ptr == wr_ptr) || hold_empty;
    assign fifo_dout  = mem[rd_ptr % DEPTH];

    // ---------------- monitor + scoreboard ----------------
    logic [DATA_W:0] exp_q[$];
    int xfer_cyc[$];
    int pop_cyc[$];
    int cyc = 0;
    int total_pops = 0;
    int done_seen = 0;
    int empty_pop_err = 0;
    int full_pop_err = 0;
    int hold_err = 0;
    int outstanding = 0;
    logic prev_stall = 1'b0;
    logic [DATA_W:0] prev_word = '0;
    logic [DATA_W:0] exp_w;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            if (fifo_rd_en) begin
                if (fifo_empty) empty_pop_err++;
                if (outstanding >= 2) full_pop_err++;
                rd_ptr <= rd_ptr + 1;
                total_pops++;
                pop_cyc.push_back(cyc);
            end
            if (prev_stall && m_valid && ({m_last, m_data} !== prev_word)) hold_err++;
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL xfer_unexpected: got last=%0b data=%h, expected no transfer", m_last, m_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({m_last, m_data} !== exp_w) begin
                        errors++;
                        $display("FAIL xfer_word: got last=%0b data=%h, expected last=%0b data=%h",
                                 m_last, m_data, exp_w[DATA_W], exp_w[DATA_W-1:0]);
                    end
                end
                xfer_cyc.push_back(cyc);
            end
            if (done) done_seen++;
            outstanding = outstanding + (fifo_rd_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
            prev_stall  = m_valid && !m_ready;
            prev_word   = {m_last, m_data};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1; start = 1'b0; burst_len = '0; m_ready = 1'b0; hold_empty = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_words(input int n, input bit counting);
        logic [DATA_W-1:0] v;
        for (int i = 0; i < n; i++) begin
            v = counting ? DATA_W'(i + 1) : DATA_W'($urandom_range(0, 15));
            mem[wr_ptr % DEPTH] = v;
            wr_ptr = wr_ptr + 1;
            src_q.push_back(v);
        end
    endtask

    task automatic flush_fifo();
        wr_ptr = rd_ptr;
        src_q.delete();
    endtask

    task automatic clear_obs();
        exp_q.delete(); xfer_cyc.delete(); pop_cyc.delete();
        done_seen = 0; empty_pop_err = 0; full_pop_err = 0; hold_err = 0;
    endtask

    // Expected output = first len words of the FIFO, last flag on the final.
    task automatic run_burst(input int len, input int ready_mode, input int stall_mode,
                             input bit poke, output bit ok);
        int k;
        int stall_cnt;
        int pops0;
        logic lst;
        logic [DATA_W:0] w;
        pops0 = total_pops; stall_cnt = 0; ok = 1'b0;
        for (int i = 0; i < len; i++) begin
            lst = (i == len - 1);
            w = {lst, src_q.pop_front()};
            exp_q.push_back(w);
        end
        start = 1'b1; burst_len = LEN_W'(len);
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!ok && k < 400) begin
            if (done) ok = 1'b1;
            else begin
                case (ready_mode)
                    1:       m_ready = (k % 4 == 0) || (k % 4 == 3);
                    2:       m_ready = 1'($urandom_range(0, 1));
                    default: m_ready = 1'b1;
                endcase
                if (stall_mode == 1) begin
                    hold_empty = (total_pops - pops0 >= 2) && (stall_cnt < 5);
                    if (hold_empty) stall_cnt++;
                end else if (stall_mode == 2) begin
                    hold_empty = ($urandom_range(0, 3) == 0);
                end else begin
                    hold_empty = 1'b0;
                end
                if (poke && busy && ($urandom_range(0, 4) == 0)) begin
                    start = 1'b1; burst_len = LEN_W'($urandom_range(1, 9));
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                k++;
            end
        end
        start = 1'b0; hold_empty = 1'b0; m_ready = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; burst_len = '0; m_ready = 1'b0; hold_empty = 1'b0;
        repeat (2) @(negedge clk);
        checks += 7;
        if (m_valid !== 1'b0)    begin errors++; $display("FAIL reset_m_valid: got %b, expected 0", m_valid); end
        if (m_last !== 1'b0)     begin errors++; $display("FAIL reset_m_last: got %b, expected 0", m_last); end
        if (m_data !== '0)       begin errors++; $display("FAIL reset_m_data: got %h, expected 0", m_data); end
        if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b, expected 0", fifo_rd_en); end
        if (fsm_state !== IDLE)  begin errors++; $display("FAIL reset_state: got %0d, expected IDLE", fsm_state); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        int pops0;
        clear_obs(); flush_fifo();
        load_words(4, 1'b1);
        pops0 = total_pops;
        run_burst(4, 0, 0, 1'b0, ok);
        @(negedge clk);
        checks += 7;
        if (ok !== 1'b1) begin errors++; $display("FAIL basic_timeout: done not seen, expected within bound"); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL basic_words_left: got %0d pending, expected 0", exp_q.size()); end
        if (total_pops - pops0 != 4) begin errors++; $display("FAIL basic_pops: got %0d, expected 4", total_pops - pops0); end
        if (done_seen != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d, expected 1", done_seen); end
        if (xfer_cyc.size() != 4 || xfer_cyc[xfer_cyc.size()-1] - xfer_cyc[0] != 3) begin
            errors++; $display("FAIL basic_consecutive: got %0d transfers, expected 4 back-to-back", xfer_cyc.size());
        end
        if (pop_cyc.size() == 0 || xfer_cyc.size() == 0 || xfer_cyc[0] != pop_cyc[0] + 1) begin
            errors++; $display("FAIL basic_latency: first pop/transfer not one cycle apart, expected 1");
        end
        if (busy !== 1'b0 || fsm_state !== IDLE) begin
            errors++; $display("FAIL basic_end_idle: got busy=%b state=%0d, expected 0/IDLE", busy, fsm_state);
        end
    endtask

    task automatic test_partial();
        bit ok;
        int pops0;
        clear_obs(); flush_fifo();
        load_words(5, 1'b0);
        pops0 = total_pops;
        run_burst(3, 0, 0, 1'b0, ok);
        repeat (5) @(negedge clk);
        checks += 5;
        if (ok !== 1'b1) begin errors++; $display("FAIL partial_timeout: done not seen, expected within bound"); end
        if (total_pops - pops0 != 3) begin errors++; $display("FAIL partial_pops: got %0d, expected 3", total_pops - pops0); end
        if (wr_ptr - rd_ptr != src_q.size()) begin
            errors++; $display("FAIL partial_remaining: got %0d, expected %0d", wr_ptr - rd_ptr, src_q.size());
        end
        if (exp_q.size() != 0) begin errors++; $display("FAIL partial_words_left: got %0d, expected 0", exp_q.size()); end
        if (done_seen != 1) begin errors++; $display("FAIL partial_done_pulses: got %0d, expected 1", done_seen); end
        flush_fifo();
    endtask

    task automatic test_backpressure();
        bit ok;
        int pops0;
        clear_obs(); flush_fifo();
        load_words(6, 1'b0);
        pops0 = total_pops;
        run_burst(6, 1, 0, 1'b0, ok);
        @(negedge clk);
        checks += 5;
        if (ok !== 1'b1) begin errors++; $display("FAIL bp_timeout: done not seen, expected within bound"); end
        if (total_pops - pops0 != 6) begin errors++; $display("FAIL bp_pops: got %0d, expected 6", total_pops - pops0); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL bp_words_left: got %0d, expected 0", exp_q.size()); end
        if (hold_err != 0) begin errors++; $display("FAIL bp_stable: got %0d changes during stall, expected 0", hold_err); end
        if (full_pop_err != 0) begin errors++; $display("FAIL bp_pop_when_full: got %0d, expected 0", full_pop_err); end
    endtask

    task automatic test_empty_stall();
        bit ok;
        int pops0;
        clear_obs(); flush_fifo();
        load_words(4, 1'b0);
        pops0 = total_pops;
        run_burst(4, 0, 1, 1'b0, ok);
        @(negedge clk);
        checks += 5;
        if (ok !== 1'b1) begin errors++; $display("FAIL stall_timeout: done not seen, expected within bound"); end
        if (total_pops - pops0 != 4) begin errors++; $display("FAIL stall_pops: got %0d, expected 4", total_pops - pops0); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL stall_words_left: got %0d, expected 0", exp_q.size()); end
        if (empty_pop_err != 0) begin errors++; $display("FAIL stall_pop_empty: got %0d, expected 0", empty_pop_err); end
        if (xfer_cyc.size() != 4 || xfer_cyc[2] - xfer_cyc[1] < 5) begin
            errors++; $display("FAIL stall_gap: got %0d transfers, expected 4 with a gap of at least 5 cycles", xfer_cyc.size());
        end
    endtask

    task automatic test_zero_len();
        int pops0;
        clear_obs(); flush_fifo();
        load_words(2, 1'b0);
        pops0 = total_pops;
        start = 1'b1; burst_len = '0;
        @(negedge clk);
        start = 1'b0;
        checks += 3;
        if (done !== 1'b1)       begin errors++; $display("FAIL zero_done: got %b, expected 1", done); end
        if (busy !== 1'b1)       begin errors++; $display("FAIL zero_busy: got %b, expected 1", busy); end
        if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL zero_rd_en: got %b, expected 0", fifo_rd_en); end
        @(negedge clk);
        checks += 3;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_after: got done=%b busy=%b, expected 0/0", done, busy);
        end
        if (fsm_state !== IDLE) begin errors++; $display("FAIL zero_state: got %0d, expected IDLE", fsm_state); end
        if (total_pops != pops0) begin errors++; $display("FAIL zero_pops: got %0d, expected 0", total_pops - pops0); end
        flush_fifo();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int k;
        int pops0;
        logic lst;
        logic [DATA_W:0] w;
        clear_obs(); flush_fifo();
        load_words(5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            lst = (i == 4);
            w = {lst, src_q.pop_front()};
            exp_q.push_back(w);
        end
        m_ready = 1'b1;
        start = 1'b1; burst_len = LEN_W'(5);
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (exp_q.size() > 3 && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (exp_q.size() > 3) begin errors++; $display("FAIL rstmid_timeout: got %0d transfers, expected 2", 5 - exp_q.size()); end
        rst = 1'b1;
        #1;
        checks += 2;
        if ({m_valid, m_last, m_data, done, busy, fifo_rd_en} !== '0) begin
            errors++; $display("FAIL rstmid_outputs: got v=%b l=%b d=%h done=%b busy=%b rd=%b, expected all 0",
                               m_valid, m_last, m_data, done, busy, fifo_rd_en);
        end
        if (fsm_state !== IDLE) begin errors++; $display("FAIL rstmid_state: got %0d, expected IDLE", fsm_state); end
        @(negedge clk);
        rst = 1'b0;
        clear_obs(); flush_fifo();
        @(negedge clk);
        load_words(2, 1'b0);
        pops0 = total_pops;
        run_burst(2, 0, 0, 1'b0, ok);
        @(negedge clk);
        checks += 4;
        if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_retry_timeout: done not seen, expected within bound"); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL rstmid_words_left: got %0d, expected 0", exp_q.size()); end
        if (total_pops - pops0 != 2) begin errors++; $display("FAIL rstmid_pops: got %0d, expected 2", total_pops - pops0); end
        if (done_seen != 1) begin errors++; $display("FAIL rstmid_done_pulses: got %0d, expected 1", done_seen); end
    endtask

    task automatic test_random();
        bit ok;
        int len;
        int pops0;
        for (int it = 0; it < 6; it++) begin
            clear_obs(); flush_fifo();
            len = $urandom_range(1, 8);
            load_words(len + $urandom_range(0, 2), 1'b0);
            pops0 = total_pops;
            run_burst(len, 2, 2, 1'b1, ok);
            repeat (3) @(negedge clk);
            checks += 5;
            if (ok !== 1'b1) begin errors++; $display("FAIL rand_timeout: iter %0d done not seen, expected within bound", it); end
            if (exp_q.size() != 0) begin errors++; $display("FAIL rand_words_left: iter %0d got %0d, expected 0", it, exp_q.size()); end
            if (total_pops - pops0 != len) begin
                errors++; $display("FAIL rand_pops: iter %0d got %0d, expected %0d", it, total_pops - pops0, len);
            end
            if (wr_ptr - rd_ptr != src_q.size()) begin
                errors++; $display("FAIL rand_remaining: iter %0d got %0d, expected %0d", it, wr_ptr - rd_ptr, src_q.size());
            end
            if (done_seen != 1 || hold_err != 0) begin
                errors++; $display("FAIL rand_done_hold: iter %0d got done=%0d holderr=%0d, expected 1/0", it, done_seen, hold_err);
            end
        end
        flush_fifo();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        rst = 1'b1; start = 1'b0; burst_len = '0; m_ready = 1'b0; hold_empty = 1'b0;
        test_reset();
        test_basic();
        test_partial();
        test_backpressure();
        test_empty_stall();
        test_zero_len();
        test_reset_mid();
        do_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 4: word width.
REQ-002 SHALL have parameter LEN_W, default 8: burst-length counter width.
REQ-003 SHALL have port clk, input, 1: clock, rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1: one-cycle burst request, honoured only in IDLE.
REQ-006 SHALL have port burst_len, input, LEN_W: number of words to drain, sampled with start.
REQ-007 SHALL have port busy, output, 1: high in RUN and DONE.
REQ-008 SHALL have port done, output, 1: one-cycle pulse when the burst completes.
REQ-009 SHALL have port fifo_empty, input, 1: upstream FIFO empty flag.
REQ-010 SHALL have port fifo_dout, input, DATA_W: show-ahead head word, valid whenever fifo_empty=0.
REQ-011 SHALL have port fifo_rd_en, output, 1: pop strobe; the next head appears on fifo_dout the following cycle.
REQ-012 SHALL have port m_valid, output, 1: downstream word valid.
REQ-013 SHALL have port m_data, output, DATA_W: downstream word.
REQ-014 SHALL have port m_last, output, 1: marks the final word of the burst, qualified by m_valid.
REQ-015 SHALL have port m_ready, input, 1: downstream accept; transfer occurs when m_valid & m_ready.

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-017 SHALL, in IDLE with start=1 and burst_len>0, latch burst_len into pop_cnt and out_cnt and enter RUN.
REQ-018 SHALL, in IDLE with start=1 and burst_len=0, enter DONE directly without popping.
REQ-019 SHALL assert fifo_rd_en = (state==RUN) & ~fifo_empty & (pop_cnt!=0) & (occ<2), with no combinational path from m_ready.
REQ-020 SHALL capture fifo_dout into a 2-entry output buffer on the same edge as the pop, and decrement pop_cnt.
REQ-021 SHALL present buffer entries in order; m_data/m_valid/m_last SHALL be registered outputs.
REQ-022 SHALL hold m_data and m_last stable while m_valid=1 and m_ready=0.
REQ-023 SHALL decrement out_cnt on each transfer, and assert m_last on the word for which out_cnt==1.
REQ-024 SHALL give latency of one cycle (pop in cycle N -> m_valid in N+1), with sustained throughput of 1 word/cycle while m_ready=1 and fifo_empty=0.
REQ-025 SHALL handle a simultaneous pop and transfer with occ unchanged and correct ordering.
REQ-026 SHALL, on the final transfer in RUN, enter DONE; DONE SHALL pulse done for exactly one cycle and then return to IDLE.
REQ-027 SHALL ignore start while busy=1.
REQ-028 SHALL, if fifo_empty rises mid-burst, stall without error and resume when it falls.
REQ-029 SHALL keep all counters LEN_W bits wide; out_cnt and pop_cnt SHALL never wrap below zero.

Reset
REQ-030 SHALL, on rst, asynchronously force state=IDLE, occ=0, pop_cnt=0, out_cnt=0, m_valid=0, m_last=0, m_data=0, done=0, busy=0, fifo_rd_en=0.
REQ-031 SHALL discard a burst in progress on mid-operation reset; words already popped are lost.

Structure
REQ-032 SHALL place the FSM state enum (IDLE, RUN, DONE) in a shared package fifo_rw_pkg.
REQ-033 SHALL implement the 2-entry output buffer as sub-module skid_buf2, parameterised by DATA_W, carrying {last,data}.

Verification
REQ-034 SHALL verify: FIFO preloaded with 4 words (0x1,0x2,0x3,0x4), start with burst_len=4, m_ready=1 -> 4 consecutive transfers, m_last on 0x4, done pulses once, 4 pops total.
REQ-035 SHALL verify: burst_len=3, FIFO holds 5 words -> exactly 3 pops, 2 words remain in the FIFO, fifo_rd_en never asserted after the third pop.
REQ-036 SHALL verify: burst_len=6 with m_ready toggled 1,0,0,1 repeating -> order preserved, no pop when occ=2, m_data stable during stalls.
REQ-037 SHALL verify: burst_len=4 with FIFO empty for 5 cycles after the second word -> stall, then completion with m_last on the fourth word.
REQ-038 SHALL verify: start with burst_len=0 -> no pop, done one cycle after start, back in IDLE after that.
REQ-039 SHALL verify: rst asserted after 2 of 5 transfers -> all outputs 0 immediately, IDLE, and a new burst_len=2 burst completes normally.
